// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the fetch-stage next-PC logic.
//   XLEN_DEF     : default PC / target width; also the width of redirect_t.target
//   RESET_PC_DEF : default PC value loaded on reset
//   PC_INC_DEF   : sequential fetch increment
//   CH_W_MAX     : width of the channel-index field carried in redirect_t
//   fetch_state_e: IDLE (no pending redirect) / HOLD (stalled redirect held)
//   redirect_t   : a resolved redirect {target, ch, misalign}
package fetch_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          PC_INC_DEF   = 4;
   localparam int          CH_W_MAX     = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] target;
      logic [CH_W_MAX-1:0] ch;
      logic                misalign;
   } redirect_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// fetch_redirect_sel -- combinational redirect resolution.
//   Per channel the target is either the branch target as given or the JALR
//   sum (base + offset, bit0 cleared). The lowest-index valid channel wins.
//   Bit1 of the winning target is reported as misalign and forced to 0.
// Ports:
//   redir_valid_i   [NUM_CH]       per-channel request
//   redir_jalr_i    [NUM_CH]       1 = JALR, 0 = branch
//   redir_target_i  [NUM_CH*XLEN]  branch targets
//   jalr_base_i     [NUM_CH*XLEN]  JALR rs1 values
//   jalr_offset_i   [NUM_CH*XLEN]  JALR immediates
//   sel_o           redirect_t     winning redirect (zero when none valid)
//   any_valid_o     1              some channel is requesting
module fetch_redirect_sel
   import fetch_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]      redir_valid_i,
   input  logic [NUM_CH-1:0]      redir_jalr_i,
   input  logic [NUM_CH*XLEN-1:0] redir_target_i,
   input  logic [NUM_CH*XLEN-1:0] jalr_base_i,
   input  logic [NUM_CH*XLEN-1:0] jalr_offset_i,
   output redirect_t              sel_o,
   output logic                   any_valid_o
);

   logic [XLEN-1:0] raw_tgt;
   logic [XLEN-1:0] jalr_sum;

   // Scan from the highest index down so the lowest-index valid channel is
   // the last writer and therefore wins.
   always_comb begin
      sel_o       = '0;
      any_valid_o = 1'b0;
      raw_tgt     = '0;
      jalr_sum    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (redir_valid_i[i]) begin
            jalr_sum = jalr_base_i[i*XLEN +: XLEN] + jalr_offset_i[i*XLEN +: XLEN];
            if (redir_jalr_i[i]) begin
               raw_tgt = {jalr_sum[XLEN-1:1], 1'b0};
            end else begin
               raw_tgt = redir_target_i[i*XLEN +: XLEN];
            end
            any_valid_o    = 1'b1;
            sel_o.ch       = CH_W_MAX'(i);
            sel_o.misalign = raw_tgt[1];
            sel_o.target   = {raw_tgt[XLEN-1:2], 2'b00};
         end
      end
   end

endmodule

// File: rtl/fetch_pc_redirect.sv
// fetch_pc_redirect -- next-PC generator for the fetch stage.
//   Owns the PC register. Advances by PC_INC when pc_write=1, takes the
//   highest-priority redirect when one is presented, and parks a redirect
//   that arrives during a stall until pc_write returns.
//   XLEN must equal fetch_pkg::XLEN_DEF (width of redirect_t.target).
// Ports:
//   clk                 clock, rising edge
//   rstn                asynchronous reset, active HIGH despite the name
//   pc_write            1 = PC may advance, 0 = stall
//   redir_valid/jalr    per-channel request / JALR select
//   redir_target        branch targets, channel i at [i*XLEN +: XLEN]
//   jalr_base           JALR rs1 values
//   jalr_target_offset  JALR sign-extended immediates
//   pc_o                current fetch PC
//   redirect_taken_o    1-cycle pulse: pc_o loaded from a redirect
//   pending_o           a stalled redirect is held
//   misalign_o          1-cycle pulse: applied target had bit1 set
//   sel_ch_o            channel of the last applied redirect
module fetch_pc_redirect
   import fetch_pkg::*;
#(
   parameter int          XLEN     = XLEN_DEF,
   parameter int          NUM_CH   = 2,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int          PC_INC   = PC_INC_DEF,
   localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   pc_write,
   input  logic [NUM_CH-1:0]      redir_valid,
   input  logic [NUM_CH-1:0]      redir_jalr,
   input  logic [NUM_CH*XLEN-1:0] redir_target,
   input  logic [NUM_CH*XLEN-1:0] jalr_base,
   input  logic [NUM_CH*XLEN-1:0] jalr_target_offset,
   output logic [XLEN-1:0]        pc_o,
   output logic                   redirect_taken_o,
   output logic                   pending_o,
   output logic                   misalign_o,
   output logic [CH_W-1:0]        sel_ch_o
);

   redirect_t    live_sel;
   logic         any_valid;

   fetch_state_e state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   redirect_t    pend_q, pend_d;
   logic         taken_q, taken_d;
   logic         mis_q, mis_d;
   logic [CH_W-1:0] sel_ch_q, sel_ch_d;

   redirect_t    apply_r;
   logic         apply;

   fetch_redirect_sel #(
      .XLEN   (XLEN),
      .NUM_CH (NUM_CH)
   ) u_sel (
      .redir_valid_i  (redir_valid),
      .redir_jalr_i   (redir_jalr),
      .redir_target_i (redir_target),
      .jalr_base_i    (jalr_base),
      .jalr_offset_i  (jalr_target_offset),
      .sel_o          (live_sel),
      .any_valid_o    (any_valid)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pend_d   = pend_q;
      taken_d  = 1'b0;
      mis_d    = 1'b0;
      sel_ch_d = sel_ch_q;
      apply    = 1'b0;
      apply_r  = live_sel;

      if (pc_write) begin
         // A live redirect is younger than the held one and supersedes it.
         if (any_valid) begin
            apply   = 1'b1;
            apply_r = live_sel;
         end else if (state_q == HOLD) begin
            apply   = 1'b1;
            apply_r = pend_q;
         end else begin
            pc_d = pc_q + XLEN'(PC_INC);
         end
         state_d = IDLE;
      end else if (any_valid) begin
         // Stalled: park (or overwrite) the redirect, PC holds.
         pend_d  = live_sel;
         state_d = HOLD;
      end

      if (apply) begin
         pc_d     = apply_r.target;
         taken_d  = 1'b1;
         mis_d    = apply_r.misalign;
         sel_ch_d = apply_r.ch[CH_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         pend_q   <= '0;
         taken_q  <= 1'b0;
         mis_q    <= 1'b0;
         sel_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         taken_q  <= taken_d;
         mis_q    <= mis_d;
         sel_ch_q <= sel_ch_d;
      end
   end

   assign pc_o             = pc_q;
   assign redirect_taken_o = taken_q;
   assign pending_o        = (state_q == HOLD);
   assign misalign_o       = mis_q;
   assign sel_ch_o         = sel_ch_q;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
module tb_fetch_pc_redirect;

   localparam int XLEN   = 32;
   localparam int NUM_CH = 2;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic                   pc_write;
   logic [NUM_CH-1:0]      redir_valid;
   logic [NUM_CH-1:0]      redir_jalr;
   logic [NUM_CH*XLEN-1:0] redir_target;
   logic [NUM_CH*XLEN-1:0] jalr_base;
   logic [NUM_CH*XLEN-1:0] jalr_target_offset;
   logic [XLEN-1:0]        pc_o;
   logic                   redirect_taken_o;
   logic                   pending_o;
   logic                   misalign_o;
   logic [0:0]             sel_ch_o;

   // Per-channel stimulus, packed onto the DUT buses below.
   logic [XLEN-1:0] rt [NUM_CH];
   logic [XLEN-1:0] jb [NUM_CH];
   logic [XLEN-1:0] jo [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign redir_target[g*XLEN +: XLEN]       = rt[g];
      assign jalr_base[g*XLEN +: XLEN]          = jb[g];
      assign jalr_target_offset[g*XLEN +: XLEN] = jo[g];
   end

   fetch_pc_redirect #(.XLEN(XLEN), .NUM_CH(NUM_CH)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .pc_write           (pc_write),
      .redir_valid        (redir_valid),
      .redir_jalr         (redir_jalr),
      .redir_target       (redir_target),
      .jalr_base          (jalr_base),
      .jalr_target_offset (jalr_target_offset),
      .pc_o               (pc_o),
      .redirect_taken_o   (redirect_taken_o),
      .pending_o          (pending_o),
      .misalign_o         (misalign_o),
      .sel_ch_o           (sel_ch_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_ptgt;
   int          m_pch;
   bit          m_pmis;
   bit          m_taken;
   bit          m_mis;
   int          m_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pend = 0; m_ptgt = 0; m_pch = 0; m_pmis = 0;
      m_taken = 0; m_mis = 0; m_sel = 0;
   endtask

   // One clock edge of the reference behaviour, from the rules in words.
   task automatic model_step();
      int          win;
      logic [31:0] t;
      win = -1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win < 0 && redir_valid[i]) win = i;
      end
      t = 0;
      if (win >= 0) t = redir_jalr[win] ? ((jb[win] + jo[win]) & ~32'h1) : rt[win];
      m_taken = 0;
      m_mis   = 0;
      if (pc_write) begin
         if (win >= 0) begin
            m_pc = t & ~32'h3; m_mis = t[1]; m_sel = win; m_taken = 1;
         end else if (m_pend) begin
            m_pc = m_ptgt; m_mis = m_pmis; m_sel = m_pch; m_taken = 1;
         end else begin
            m_pc = m_pc + 32'd4;
         end
         m_pend = 0;
      end else if (win >= 0) begin
         m_pend = 1; m_ptgt = t & ~32'h3; m_pmis = t[1]; m_pch = win;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},      pc_o, m_pc);
      chk({tag, ".taken"},   32'(redirect_taken_o), 32'(m_taken));
      chk({tag, ".pending"}, 32'(pending_o), 32'(m_pend));
      chk({tag, ".mis"},     32'(misalign_o), 32'(m_mis));
      chk({tag, ".sel"},     32'(sel_ch_o), 32'(m_sel));
   endtask

   task automatic clr_in();
      redir_valid = '0; redir_jalr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rt[i] = 32'hDEAD_BEE0; jb[i] = 32'h0; jo[i] = 32'h0;
      end
   endtask

   // Apply current inputs for one edge, then compare away from the edge.
   task automatic cycle(input logic pw, input string tag);
      pc_write = pw;
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic branch(input int ch, input logic [31:0] tgt);
      redir_valid[ch] = 1'b1; redir_jalr[ch] = 1'b0; rt[ch] = tgt;
   endtask

   task automatic jalr(input int ch, input logic [31:0] b, input logic [31:0] o);
      redir_valid[ch] = 1'b1; redir_jalr[ch] = 1'b1; jb[ch] = b; jo[ch] = o;
   endtask

   initial begin
      rstn = 1'b1;
      pc_write = 1'b0;
      clr_in();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rstn = 1'b0;

      // Sequential fetch
      pc_write = 1'b1;
      for (int k = 0; k < 4; k++) cycle(1'b1, "seq");

      // ch1 branch, then sequential
      branch(1, 32'h200);
      cycle(1'b1, "br_ch1");
      clr_in();
      cycle(1'b1, "br_ch1_next");

      // ch0 JALR wins over ch1 branch
      jalr(0, 32'h1000, 32'hFFFF_FFFD);
      branch(1, 32'h500);
      cycle(1'b1, "jalr_prio");
      clr_in();
      jalr(0, 32'h1001, 32'h1);
      cycle(1'b1, "jalr_mis");
      clr_in();
      cycle(1'b1, "after_mis");

      // Stall with overwrite of pending
      branch(0, 32'h300);
      cycle(1'b0, "stall1");
      clr_in();
      branch(1, 32'h400);
      cycle(1'b0, "stall2");
      clr_in();
      cycle(1'b0, "stall3");
      cycle(1'b1, "release");
      cycle(1'b1, "release_next");

      // Live redirect supersedes pending
      branch(0, 32'h300);
      cycle(1'b0, "hold");
      clr_in();
      branch(0, 32'h800);
      cycle(1'b1, "supersede");
      clr_in();

      // Async reset in the middle of a stall
      branch(0, 32'h300);
      cycle(1'b0, "hold_rst");
      clr_in();
      #2;
      rstn = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rstn = 1'b0;
      cycle(1'b1, "post_rst1");
      cycle(1'b1, "post_rst2");

      // PC wrap
      branch(1, 32'hFFFF_FFFC);
      cycle(1'b1, "to_top");
      clr_in();
      cycle(1'b1, "wrap");

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            redir_valid[i] = ($urandom_range(0, 3) == 0);
            redir_jalr[i]  = $urandom_range(0, 1) != 0;
            rt[i] = $urandom;
            jb[i] = $urandom;
            jo[i] = $urandom;
         end
         cycle($urandom_range(0, 3) != 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // Safety net against a hang.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_pc_redirect.md
Name: fetch_pc_redirect

Overview:
- Parametrised next-PC generator for the fetch stage; generalises the single-source jalr/pc_src/pc_write control into NUM_CH redirect channels.
- Each channel carries a branch or JALR redirect.
- Owns the PC register, applies a stall (pc_write), and latches a redirect that arrives during a stall until it can be applied.
- Sits between the execute-stage redirect sources and the instruction-memory address port.

Parameters:
- XLEN, 32, PC/target/offset width.
- NUM_CH, 2, number of redirect channels; channel 0 is the oldest instruction and has the highest priority.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential increment.

Ports:
- clk  in  1  clock, rising-edge.
- rstn  in  1  reset, asynchronous, active-high.
- pc_write  in  1  1 = PC may advance this cycle; 0 = stall.
- redir_valid  in  NUM_CH  per-channel redirect request.
- redir_jalr  in  NUM_CH  1 = JALR (target = base+offset); 0 = branch (target = redir_target).
- redir_target  in  NUM_CH*XLEN  branch target, channel i at [i*XLEN +: XLEN].
- jalr_base  in  NUM_CH*XLEN  JALR rs1 value.
- jalr_target_offset  in  NUM_CH*XLEN  JALR sign-extended immediate.
- pc_o  out  XLEN  current fetch PC.
- redirect_taken_o  out  1  pulse: pc_o was loaded from a redirect on the last edge.
- pending_o  out  1  a stalled redirect is being held.
- misalign_o  out  1  pulse: the applied target had bit1 set (forced to 0).
- sel_ch_o  out  $clog2(NUM_CH) (min 1)  channel index of the last applied redirect.

Behaviour:
- Reset (async, active-high): pc_o=RESET_PC; pending_o=0; redirect_taken_o=0; misalign_o=0; sel_ch_o=0; pending target register=0. Reset mid-stall discards the pending redirect.
- Target computation, combinational per channel:
  - JALR: (jalr_base + jalr_target_offset) with bit0 cleared, mod 2^XLEN, wrap silently.
  - Branch: redir_target as given.
- Channel select: the lowest-index channel with redir_valid=1 wins. Other valid channels in the same cycle are ignored.
- Misalign check: if selected target bit1=1, the applied target has bits[1:0]=0 and misalign_o pulses 1 on the same edge the redirect is applied.
- States: IDLE (no pending) and HOLD (pending valid). pending_o = (state==HOLD).
- IDLE, pc_write=1:
  - any redir_valid: pc <= selected target; redirect_taken_o<=1.
  - else: pc <= pc + PC_INC, wrap mod 2^XLEN.
- IDLE, pc_write=0:
  - pc held.
  - If any redir_valid: pending <= selected target/channel/misalign; go to HOLD.
- HOLD, pc_write=0:
  - pc held.
  - A new redir_valid overwrites pending. The later redirect is younger and on the corrected path.
- HOLD, pc_write=1:
  - If redir_valid: the live selected redirect is applied (it supersedes pending).
  - Else: pending is applied.
  - Either way: redirect_taken_o<=1, go to IDLE.
- Latency: redirect to pc_o is 1 cycle when not stalled; the stall adds exactly the stall cycles.
- Pulse outputs: redirect_taken_o and misalign_o are 1 for one cycle per applied redirect and otherwise 0. sel_ch_o updates only when a redirect is applied.
- X-safety: redir_target, jalr_base and jalr_target_offset are don't-care when the corresponding redir_valid=0.

Decomposition:
- Package fetch_pkg: XLEN default, RESET_PC default, PC_INC, state enum {IDLE, HOLD}, and a typedef redirect_t {target, ch, misalign}.
- One sub-module: fetch_redirect_sel. It is combinational: per-channel target add, fixed-priority select, misalign detect. It outputs a redirect_t plus an any_valid flag.
- The top holds the PC, the pending register and the FSM.

Test Plan:
- Reset release, pc_write=1, no redirects, 4 cycles -> pc_o 0x0, 0x4, 0x8, 0xC, 0x10; all pulse outputs 0.
- ch1 branch target 0x200 with pc_write=1 -> next cycle pc_o=0x200, redirect_taken_o=1, sel_ch_o=1, then 0x204.
- ch0 JALR base 0x1000, offset 0xFFFF_FFFD (-3) -> target 0x0FFC; ch1 simultaneously valid with 0x500 -> pc_o=0x0FFC, sel_ch_o=0. Then JALR base 0x1001, offset 1 -> 0x1002 forced to 0x1000, misalign_o=1.
- pc_write=0 for 3 cycles:
  - ch0 branch 0x300 in stall cycle 1 -> pending_o=1, pc_o held.
  - ch1 0x400 in stall cycle 2 -> overwrites pending.
  - pc_write=1 -> pc_o=0x400, pending_o=0.
- HOLD with pending 0x300, then pc_write=1 together with live ch0 0x800 -> pc_o=0x800.
- HOLD with pending; assert rstn mid-stall -> pc_o=RESET_PC immediately (async), pending_o=0; after release, pc advances from 0x0.
- PC wrap: pc_o=0xFFFF_FFFC, pc_write=1 -> pc_o=0x0000_0000.
